// File: rtl/apu_frame_counter.sv
// APU frame sequencer: derives APU-cycle, quarter-frame, half-frame strobes and frame IRQ from the CPU-cycle strobe.
// Optional: define APU_FRAME_IRQ_EN to build the frame IRQ flag, inhibit bit and $4015-read clear.
module apu_frame_counter #(
  parameter int unsigned CNT_BITS = 16,
  parameter int unsigned STEP1    = 7457,
  parameter int unsigned STEP2    = 14913,
  parameter int unsigned STEP3    = 22371,
  parameter int unsigned STEP4    = 29829,
  parameter int unsigned STEP5    = 37281
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       cpu_cycle_pulse_in,
  input  logic       wr_in,
  input  logic [7:0] d_in,
  input  logic       rd_status_in,
  output logic       apu_cycle_pulse_out,
  output logic       eg_pulse_out,
  output logic       lc_pulse_out,
  output logic       frame_irq_out,
  output logic       mode_out
);

  localparam int unsigned DLY_W = 3;
  localparam logic [CNT_BITS-1:0] S1   = CNT_BITS'(STEP1);
  localparam logic [CNT_BITS-1:0] S2   = CNT_BITS'(STEP2);
  localparam logic [CNT_BITS-1:0] S3   = CNT_BITS'(STEP3);
  localparam logic [CNT_BITS-1:0] S4M1 = CNT_BITS'(STEP4 - 1);
  localparam logic [CNT_BITS-1:0] S4   = CNT_BITS'(STEP4);
  localparam logic [CNT_BITS-1:0] S4P1 = CNT_BITS'(STEP4 + 1);
  localparam logic [CNT_BITS-1:0] S5   = CNT_BITS'(STEP5);
  localparam logic [CNT_BITS-1:0] S5P1 = CNT_BITS'(STEP5 + 1);

  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic                phase_q, phase_d;
  logic                mode_q;
  logic                apu_q, apu_d;
  logic                eg_q, eg_d;
  logic                lc_q, lc_d;
  logic                irq_set_c;
  logic [CNT_BITS-1:0] fin_c, end_c;

  // Event decode on the pre-increment count; a reload expiring overrides the decode.
  always_comb begin
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    phase_d   = phase_q;
    apu_d     = 1'b0;
    eg_d      = 1'b0;
    lc_d      = 1'b0;
    irq_set_c = 1'b0;
    fin_c     = mode_q ? S5 : S4;
    end_c     = mode_q ? S5P1 : S4P1;
    if (cpu_cycle_pulse_in) begin
      phase_d   = ~phase_q;
      apu_d     = phase_q;
      eg_d      = (cnt_q == S1) || (cnt_q == S2) || (cnt_q == S3) || (cnt_q == fin_c);
      lc_d      = (cnt_q == S2) || (cnt_q == fin_c);
      irq_set_c = !mode_q && ((cnt_q == S4M1) || (cnt_q == S4) || (cnt_q == S4P1));
      cnt_d     = (cnt_q >= end_c) ? '0 : CNT_BITS'(cnt_q + CNT_BITS'(1));
      if (dly_q != '0) begin
        dly_d = DLY_W'(dly_q - DLY_W'(1));
        if (dly_q == DLY_W'(1)) begin
          cnt_d     = '0;
          eg_d      = mode_q;
          lc_d      = mode_q;
          irq_set_c = 1'b0;
        end
      end
    end
    // A $4017 write (re)starts the reload delay, aligned to the APU phase.
    if (wr_in) dly_d = phase_q ? DLY_W'(3) : DLY_W'(4);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q   <= '0;
      dly_q   <= '0;
      phase_q <= 1'b0;
      mode_q  <= 1'b0;
      apu_q   <= 1'b0;
      eg_q    <= 1'b0;
      lc_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      phase_q <= phase_d;
      apu_q   <= apu_d;
      eg_q    <= eg_d;
      lc_q    <= lc_d;
      if (wr_in) mode_q <= d_in[7];
    end
  end

  assign apu_cycle_pulse_out = apu_q;
  assign eg_pulse_out        = eg_q;
  assign lc_pulse_out        = lc_q;
  assign mode_out            = mode_q;

`ifdef APU_FRAME_IRQ_EN
  logic irq_q, inhibit_q;
  logic unused_c;

  // Inhibit write beats a set; a set beats a status-read clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      irq_q     <= 1'b0;
      inhibit_q <= 1'b0;
    end else begin
      if (wr_in) inhibit_q <= d_in[6];
      if (wr_in && d_in[6])             irq_q <= 1'b0;
      else if (irq_set_c && !inhibit_q) irq_q <= 1'b1;
      else if (rd_status_in)            irq_q <= 1'b0;
    end
  end

  assign frame_irq_out = irq_q;
  assign unused_c      = ^d_in[5:0];
`else
  logic unused_c;
  assign frame_irq_out = 1'b0;
  assign unused_c      = ^{d_in[6:0], rd_status_in, irq_set_c};
`endif

endmodule

// File: tb/tb_apu_frame_counter.sv
// Randomised self-checking bench for apu_frame_counter against a count-based reference model.
module tb_apu_frame_counter;

  localparam int S1 = 57;
  localparam int S2 = 115;
  localparam int S3 = 173;
  localparam int S4 = 231;
  localparam int S5 = 289;
`ifdef APU_FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       strobe = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] din = 8'h00;
  logic       apu, eg, lc, irq, mode;
  logic [4:0] obs;

  int ncmp = 0;
  int nfail = 0;

  // reference model state
  int m_cnt, m_dly;
  bit m_mode, m_inh, m_phase, m_irq, m_apu, m_eg, m_lc;

  always #5 clk_in = ~clk_in;
  assign obs = {apu, eg, lc, irq, mode};

  apu_frame_counter #(
    .CNT_BITS(16), .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .cpu_cycle_pulse_in(strobe),
    .wr_in(wr),
    .d_in(din),
    .rd_status_in(rd),
    .apu_cycle_pulse_out(apu),
    .eg_pulse_out(eg),
    .lc_pulse_out(lc),
    .frame_irq_out(irq),
    .mode_out(mode)
  );

  function automatic logic [4:0] exp_vec();
    return {m_apu, m_eg, m_lc, m_irq, m_mode};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_dly = 0; m_mode = 0; m_inh = 0; m_phase = 0;
    m_irq = 0; m_apu = 0; m_eg = 0; m_lc = 0;
  endtask

  // One clock of the frame-sequencer rules, applied to the inputs seen at that edge.
  task automatic model_edge(input bit s, input bit w, input logic [7:0] d, input bit r);
    int eg_steps[4];
    int fin;
    bit set;
    bit ph_before;
    ph_before = m_phase;
    set = 0;
    m_apu = 0; m_eg = 0; m_lc = 0;
    if (s) begin
      fin = m_mode ? S5 : S4;
      eg_steps = '{S1, S2, S3, fin};
      foreach (eg_steps[i]) if (m_cnt == eg_steps[i]) m_eg = 1;
      m_lc = (m_cnt == S2) || (m_cnt == fin);
      set = !m_mode && (m_cnt >= S4 - 1) && (m_cnt <= S4 + 1);
      m_apu = m_phase;
      m_cnt = (m_cnt >= fin + 1) ? 0 : m_cnt + 1;
      if (m_dly > 0) begin
        m_dly--;
        if (m_dly == 0) begin
          m_cnt = 0; m_eg = m_mode; m_lc = m_mode; set = 0;
        end
      end
      m_phase = !m_phase;
    end
    if (IRQ_EN) begin
      if (w && d[6])          m_irq = 0;
      else if (set && !m_inh) m_irq = 1;
      else if (r)             m_irq = 0;
    end
    if (w) begin
      m_dly  = ph_before ? 3 : 4;
      m_mode = d[7];
      m_inh  = IRQ_EN && d[6];
    end
  endtask

  task automatic cyc(input bit s, input bit w, input logic [7:0] d, input bit r);
    strobe = s; wr = w; din = d; rd = r;
    @(posedge clk_in);
    model_edge(s, w, d, r);
    #1;
    strobe = 0; wr = 0; rd = 0; din = 8'h00;
  endtask

  task automatic adv(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (m_cnt == target) begin
        ok = 1;
        break;
      end
      cyc(1, 0, 8'h00, 0);
    end
  endtask

  task automatic test_reset();
    rst_n_in = 0;
    repeat (3) @(posedge clk_in);
    #1;
    ncmp++;
    if (obs !== 5'b0) begin nfail++; $display("FAIL reset_hold got=%b exp=%b", obs, 5'b0); end
    @(negedge clk_in);
    rst_n_in = 1;
    model_reset();
    cyc(0, 0, 8'h00, 0);
    ncmp++;
    if (obs !== exp_vec()) begin nfail++; $display("FAIL reset_release got=%b exp=%b", obs, exp_vec()); end
  endtask

  task automatic test_four_step();
    int neg = 0, nlc = 0, ns = 0;
    bit s;
    while (ns < S4 + 2) begin
      s = ($urandom_range(0, 3) != 0);
      cyc(s, 0, 8'h00, 0);
      if (s) ns++;
      if (eg) neg++;
      if (lc) nlc++;
      ncmp++;
      if (obs !== exp_vec()) begin nfail++; $display("FAIL four_step_vec t=%0t got=%b exp=%b", $time, obs, exp_vec()); end
    end
    ncmp++;
    if (neg !== 4) begin nfail++; $display("FAIL four_step_eg_count got=%0d exp=4", neg); end
    ncmp++;
    if (nlc !== 2) begin nfail++; $display("FAIL four_step_lc_count got=%0d exp=2", nlc); end
    ncmp++;
    if (irq !== IRQ_EN) begin nfail++; $display("FAIL four_step_irq got=%b exp=%b", irq, IRQ_EN); end
    ns = 0;
    while (ns < S4 + 2) begin
      s = ($urandom_range(0, 3) != 0);
      cyc(s, 0, 8'h00, 0);
      if (s) ns++;
      ncmp++;
      if (obs !== exp_vec()) begin nfail++; $display("FAIL four_step_frame2 t=%0t got=%b exp=%b", $time, obs, exp_vec()); end
    end
  endtask

  task automatic test_five_step();
    int neg = 0, nlc = 0, ns = 0;
    bit s;
    cyc(0, 0, 8'h00, 1);
    ncmp++;
    if (irq !== 1'b0) begin nfail++; $display("FAIL five_pre_clear got=%b exp=0", irq); end
    if (m_phase) cyc(1, 0, 8'h00, 0);
    cyc(0, 1, 8'h80, 0);
    ncmp++;
    if (mode !== 1'b1) begin nfail++; $display("FAIL five_mode_out got=%b exp=1", mode); end
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 0, 8'h00, 0);
      ncmp++;
      if (obs !== exp_vec()) begin nfail++; $display("FAIL five_reload_vec k=%0d got=%b exp=%b", k, obs, exp_vec()); end
    end
    ncmp++;
    if ({eg, lc} !== 2'b11) begin nfail++; $display("FAIL five_reload_4 got=%b exp=11", {eg, lc}); end
    while (ns < S5 + 2) begin
      s = ($urandom_range(0, 3) != 0);
      cyc(s, 0, 8'h00, 0);
      if (s) ns++;
      if (eg) neg++;
      if (lc) nlc++;
      ncmp++;
      if (obs !== exp_vec()) begin nfail++; $display("FAIL five_step_vec t=%0t got=%b exp=%b", $time, obs, exp_vec()); end
    end
    ncmp++;
    if (neg !== 4) begin nfail++; $display("FAIL five_step_eg_count got=%0d exp=4", neg); end
    ncmp++;
    if (nlc !== 2) begin nfail++; $display("FAIL five_step_lc_count got=%0d exp=2", nlc); end
  endtask

  task automatic test_phase1_back_to_back();
    int n, exp_n;
    if (!m_phase) cyc(1, 0, 8'h00, 0);
    cyc(0, 1, 8'h80, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1, 0, 8'h00, 0);
      ncmp++;
      if (obs !== exp_vec()) begin nfail++; $display("FAIL ph1_vec k=%0d got=%b exp=%b", k, obs, exp_vec()); end
    end
    ncmp++;
    if ({eg, lc} !== 2'b11) begin nfail++; $display("FAIL ph1_reload_3 got=%b exp=11", {eg, lc}); end
    cyc(0, 1, 8'h80, 0);
    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
    exp_n = m_phase ? 3 : 4;
    cyc(0, 1, 8'h80, 0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1, 0, 8'h00, 0);
      n++;
      ncmp++;
      if (obs !== exp_vec()) begin nfail++; $display("FAIL b2b_vec k=%0d got=%b exp=%b", k, obs, exp_vec()); end
      if (eg && lc) break;
    end
    ncmp++;
    if (n !== exp_n) begin nfail++; $display("FAIL b2b_reload_delay got=%0d exp=%0d", n, exp_n); end
    cyc(0, 1, 8'h00, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(1, 0, 8'h00, 0);
      ncmp++;
      if (obs !== exp_vec()) begin nfail++; $display("FAIL to_mode0_vec k=%0d got=%b exp=%b", k, obs, exp_vec()); end
    end
  endtask

  task automatic test_irq();
    bit ok, s, saw;
    int ns = 0;
    adv(S4 - 1, ok);
    ncmp++;
    if (!ok) begin nfail++; $display("FAIL irq_adv_timeout got=%0d exp=%0d", m_cnt, S4 - 1); end
    cyc(1, 0, 8'h00, 0);
    ncmp++;
    if (irq !== IRQ_EN) begin nfail++; $display("FAIL irq_set_first got=%b exp=%b", irq, IRQ_EN); end
    cyc(0, 0, 8'h00, 1);
    ncmp++;
    if (irq !== 1'b0) begin nfail++; $display("FAIL irq_rd_clear got=%b exp=0", irq); end
    cyc(1, 0, 8'h00, 1);
    ncmp++;
    if (irq !== IRQ_EN) begin nfail++; $display("FAIL irq_set_beats_rd got=%b exp=%b", irq, IRQ_EN); end
    cyc(0, 0, 8'h00, 1);
    ncmp++;
    if (irq !== 1'b0) begin nfail++; $display("FAIL irq_rd_clear2 got=%b exp=0", irq); end
    cyc(1, 0, 8'h00, 0);
    ncmp++;
    if (irq !== IRQ_EN) begin nfail++; $display("FAIL irq_set_last got=%b exp=%b", irq, IRQ_EN); end
    cyc(0, 1, 8'h40, 0);
    ncmp++;
    if (irq !== 1'b0) begin nfail++; $display("FAIL irq_inhibit_clear got=%b exp=0", irq); end
    saw = 0;
    while (ns < S4 + 5) begin
      s = ($urandom_range(0, 3) != 0);
      cyc(s, 0, 8'h00, ($urandom_range(0, 15) == 0));
      if (s) ns++;
      if (irq) saw = 1;
      ncmp++;
      if (obs !== exp_vec()) begin nfail++; $display("FAIL inhibit_vec t=%0t got=%b exp=%b", $time, obs, exp_vec()); end
    end
    ncmp++;
    if (saw !== 1'b0) begin nfail++; $display("FAIL inhibit_frame got=%b exp=0", saw); end
    cyc(0, 1, 8'h00, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(1, 0, 8'h00, 0);
      ncmp++;
      if (obs !== exp_vec()) begin nfail++; $display("FAIL reenable_vec k=%0d got=%b exp=%b", k, obs, exp_vec()); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    adv((S2 + S3) / 2, ok);
    ncmp++;
    if (!ok) begin nfail++; $display("FAIL rstmid_adv_timeout got=%0d exp=%0d", m_cnt, (S2 + S3) / 2); end
    cyc(0, 1, 8'h80, 0);
    ncmp++;
    if (mode !== 1'b1) begin nfail++; $display("FAIL rstmid_mode_before got=%b exp=1", mode); end
    #3;
    rst_n_in = 0;
    #1;
    ncmp++;
    if (obs !== 5'b0) begin nfail++; $display("FAIL rstmid_async got=%b exp=%b", obs, 5'b0); end
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1;
    model_reset();
    for (int k = 0; k < 1000; k++) begin
      cyc(1, 0, 8'h00, 0);
      n++;
      ncmp++;
      if (obs !== exp_vec()) begin nfail++; $display("FAIL rstmid_vec k=%0d got=%b exp=%b", k, obs, exp_vec()); end
      if (eg) break;
    end
    ncmp++;
    if (n !== S1 + 1) begin nfail++; $display("FAIL rstmid_first_eg got=%0d exp=%0d", n, S1 + 1); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_four_step();
    test_five_step();
    test_phase1_back_to_back();
    test_irq();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
